// File: rtl/avr_gpio_pkg.sv
// Shared definitions for the AVR-style GPIO port: default I/O addresses and
// the register-select decode used by the bus interface.
package avr_gpio_pkg;

    localparam logic [5:0] DEF_PINX_ADR  = 6'h03;
    localparam logic [5:0] DEF_DDRX_ADR  = 6'h04;
    localparam logic [5:0] DEF_PORTX_ADR = 6'h05;
    localparam logic [5:0] DEF_PCMSK_ADR = 6'h06;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_PIN,
        SEL_DDR,
        SEL_PORT,
        SEL_PCMSK
    } reg_sel_e;

    // Fixed priority only matters if two addresses are configured equal.
    function automatic reg_sel_e decode_adr(
        input logic [5:0] adr,
        input logic [5:0] pin_adr,
        input logic [5:0] ddr_adr,
        input logic [5:0] port_adr,
        input logic [5:0] pcmsk_adr
    );
        if (adr == pin_adr)        return SEL_PIN;
        else if (adr == ddr_adr)   return SEL_DDR;
        else if (adr == port_adr)  return SEL_PORT;
        else if (adr == pcmsk_adr) return SEL_PCMSK;
        else                       return SEL_NONE;
    endfunction

endpackage

// File: rtl/avr_sync2.sv
// Two-stage synchronizer for asynchronous pad inputs; both stages clear on
// reset so that no spurious pin change is seen after release.
module avr_sync2 #(
    parameter int W = 8
) (
    input  logic         cp2,
    input  logic         ireset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge cp2 or posedge ireset) begin
        if (ireset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/avr_gpio_port.sv
// AVR-style 8-bit GPIO port: PINx/DDRx/PORTx/PCMSK on the core I/O bus,
// pad control outputs and a pin-change interrupt flag.
module avr_gpio_port
    import avr_gpio_pkg::*;
#(
    parameter logic [5:0] PINX_ADR  = DEF_PINX_ADR,
    parameter logic [5:0] DDRX_ADR  = DEF_DDRX_ADR,
    parameter logic [5:0] PORTX_ADR = DEF_PORTX_ADR,
    parameter logic [5:0] PCMSK_ADR = DEF_PCMSK_ADR
) (
    input  logic       cp2,
    input  logic       ireset,
    input  logic       cp2en,
    input  logic [5:0] adr,
    input  logic       iore,
    input  logic       iowe,
    input  logic [7:0] dbusin,
    output logic [7:0] dbusout,
    output logic       out_en,
    input  logic       pud,
    input  logic [7:0] pin_i,
    output logic [7:0] port_o,
    output logic [7:0] ddr_o,
    output logic [7:0] pue_o,
    output logic       pcif,
    input  logic       pcif_clr
);

    reg_sel_e   sel;
    logic [7:0] port_r;
    logic [7:0] ddr_r;
    logic [7:0] pcmsk_r;
    logic [7:0] pin_sync;
    logic [7:0] pin_prev;
    logic       pc_event;

    assign sel    = decode_adr(adr, PINX_ADR, DDRX_ADR, PORTX_ADR, PCMSK_ADR);
    assign out_en = iore & (sel != SEL_NONE);

    // Read mux is purely combinational, so a simultaneous write returns the
    // pre-write value and SBI/CBI need no wait states.
    always_comb begin
        dbusout = 8'h00;
        if (iore) begin
            case (sel)
                SEL_PIN:   dbusout = pin_sync;
                SEL_DDR:   dbusout = ddr_r;
                SEL_PORT:  dbusout = port_r;
                SEL_PCMSK: dbusout = pcmsk_r;
                default:   dbusout = 8'h00;
            endcase
        end
    end

    always_ff @(posedge cp2 or posedge ireset) begin
        if (ireset) begin
            port_r  <= 8'h00;
            ddr_r   <= 8'h00;
            pcmsk_r <= 8'h00;
        end else if (cp2en && iowe) begin
            case (sel)
                SEL_PIN:   port_r  <= port_r ^ dbusin;
                SEL_DDR:   ddr_r   <= dbusin;
                SEL_PORT:  port_r  <= dbusin;
                SEL_PCMSK: pcmsk_r <= dbusin;
                default:   ;
            endcase
        end
    end

    avr_sync2 #(.W(8)) u_sync (
        .cp2    (cp2),
        .ireset (ireset),
        .d      (pin_i),
        .q      (pin_sync)
    );

    assign pc_event = |((pin_sync ^ pin_prev) & pcmsk_r);

    // Edge detection and the flag run every cycle regardless of cp2en;
    // a new event beats a same-cycle acknowledge so no change is lost.
    always_ff @(posedge cp2 or posedge ireset) begin
        if (ireset) begin
            pin_prev <= 8'h00;
            pcif     <= 1'b0;
        end else begin
            pin_prev <= pin_sync;
            pcif     <= pc_event | (pcif & ~pcif_clr);
        end
    end

    assign port_o = port_r;
    assign ddr_o  = ddr_r;
    assign pue_o  = port_r & ~ddr_r & {8{~pud}};

endmodule

// File: tb/tb_avr_gpio_port.sv
// Directed and randomized checks of avr_gpio_port against a register-level
// reference model with a pin history queue.
module tb_avr_gpio_port;

    localparam logic [5:0] A_PIN   = 6'h03;
    localparam logic [5:0] A_DDR   = 6'h04;
    localparam logic [5:0] A_PORT  = 6'h05;
    localparam logic [5:0] A_PCMSK = 6'h06;

    logic       cp2 = 1'b0;
    logic       ireset = 1'b1;
    logic       cp2en = 1'b1;
    logic [5:0] adr = 6'h00;
    logic       iore = 1'b0;
    logic       iowe = 1'b0;
    logic [7:0] dbusin = 8'h00;
    logic [7:0] dbusout;
    logic       out_en;
    logic       pud = 1'b0;
    logic [7:0] pin_i = 8'h00;
    logic [7:0] port_o;
    logic [7:0] ddr_o;
    logic [7:0] pue_o;
    logic       pcif;
    logic       pcif_clr = 1'b0;

    int n_pass  = 0;
    int n_total = 0;

    // reference model state
    logic [7:0] m_port, m_ddr, m_pcmsk;
    logic       m_pcif;
    logic [7:0] hist[$];   // pin_i values sampled at successive edges

    avr_gpio_port dut (
        .cp2      (cp2),
        .ireset   (ireset),
        .cp2en    (cp2en),
        .adr      (adr),
        .iore     (iore),
        .iowe     (iowe),
        .dbusin   (dbusin),
        .dbusout  (dbusout),
        .out_en   (out_en),
        .pud      (pud),
        .pin_i    (pin_i),
        .port_o   (port_o),
        .ddr_o    (ddr_o),
        .pue_o    (pue_o),
        .pcif     (pcif),
        .pcif_clr (pcif_clr)
    );

    always #5 cp2 = ~cp2;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [7:0] hist_back(input int k);
        if (hist.size() > k) return hist[hist.size() - 1 - k];
        return 8'h00;
    endfunction

    // synchronized pin value = pad value sampled one edge before the latest
    function automatic logic [7:0] m_sync();
        return hist_back(1);
    endfunction

    function automatic logic [7:0] m_prev();
        return hist_back(2);
    endfunction

    function automatic logic [7:0] m_rd();
        if (!iore) return 8'h00;
        if (adr == A_PIN)   return m_sync();
        if (adr == A_DDR)   return m_ddr;
        if (adr == A_PORT)  return m_port;
        if (adr == A_PCMSK) return m_pcmsk;
        return 8'h00;
    endfunction

    function automatic logic m_hit();
        return iore && (adr == A_PIN || adr == A_DDR || adr == A_PORT || adr == A_PCMSK);
    endfunction

    task automatic model_reset();
        m_port = 8'h00; m_ddr = 8'h00; m_pcmsk = 8'h00; m_pcif = 1'b0;
        hist.delete();
    endtask

    task automatic model_edge();
        logic ev;
        ev = ((m_sync() ^ m_prev()) & m_pcmsk) != 8'h00;
        m_pcif = ev || (m_pcif && !pcif_clr);
        if (cp2en && iowe) begin
            if (adr == A_PIN)        m_port  = m_port ^ dbusin;
            else if (adr == A_DDR)   m_ddr   = dbusin;
            else if (adr == A_PORT)  m_port  = dbusin;
            else if (adr == A_PCMSK) m_pcmsk = dbusin;
        end
        hist.push_back(pin_i);
        if (hist.size() > 4) void'(hist.pop_front());
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".dbusout"}, dbusout, m_rd());
        chk({tag, ".out_en"}, {7'd0, out_en}, {7'd0, m_hit()});
        chk({tag, ".port_o"}, port_o, m_port);
        chk({tag, ".ddr_o"}, ddr_o, m_ddr);
        chk({tag, ".pue_o"}, pue_o, m_port & ~m_ddr & {8{~pud}});
        chk({tag, ".pcif"}, {7'd0, pcif}, {7'd0, m_pcif});
    endtask

    // One bus cycle: drive, check combinational view, clock, advance model.
    task automatic cyc(input string tag, input logic [5:0] a, input logic re, input logic we,
                       input logic [7:0] d, input logic en, input logic [7:0] pin,
                       input logic clr);
        adr = a; iore = re; iowe = we; dbusin = d; cp2en = en; pin_i = pin; pcif_clr = clr;
        #1;
        check_all(tag);
        @(posedge cp2);
        model_edge();
        #1;
    endtask

    task automatic idle(input string tag, input logic [7:0] pin, input int n);
        for (int i = 0; i < n; i++) cyc(tag, 6'h00, 1'b0, 1'b0, 8'h00, 1'b1, pin, 1'b0);
    endtask

    initial begin
        model_reset();
        #3;
        chk("rst.port_o", port_o, 8'h00);
        chk("rst.pcif", {7'd0, pcif}, 8'h00);
        #5 ireset = 1'b0;                       // released just after the first edge
        #1;

        // register writes and pad outputs
        cyc("wr_port", A_PORT, 1'b0, 1'b1, 8'hA5, 1'b1, 8'h00, 1'b0);
        cyc("wr_ddr",  A_DDR,  1'b0, 1'b1, 8'h0F, 1'b1, 8'h00, 1'b0);
        cyc("rd_port", A_PORT, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0);
        chk("d035.port_o", port_o, 8'hA5);
        chk("d035.ddr_o", ddr_o, 8'h0F);
        chk("d035.pue_o", pue_o, 8'hA0);

        // PINx toggle
        cyc("tog81", A_PIN, 1'b0, 1'b1, 8'h81, 1'b1, 8'h00, 1'b0);
        chk("d036.tog81", port_o, 8'h24);
        cyc("tog00", A_PIN, 1'b0, 1'b1, 8'h00, 1'b1, 8'h00, 1'b0);
        chk("d036.tog00", port_o, 8'h24);

        // SBI: read then write back with bit 3 set
        cyc("sbi_rd", A_PORT, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0);
        cyc("sbi_wr", A_PORT, 1'b0, 1'b1, 8'h2C, 1'b1, 8'h00, 1'b0);
        chk("d037.port_o", port_o, 8'h2C);

        // pin change with bit 3 enabled
        cyc("msk08", A_PCMSK, 1'b0, 1'b1, 8'h08, 1'b1, 8'h00, 1'b0);
        idle("settle0", 8'h00, 3);
        cyc("pin08a", A_PIN, 1'b1, 1'b0, 8'h00, 1'b1, 8'h08, 1'b0);
        cyc("pin08b", A_PIN, 1'b1, 1'b0, 8'h00, 1'b1, 8'h08, 1'b0);
        adr = A_PIN; iore = 1'b1; #1;
        chk("d038.pin_sync", dbusout, 8'h08);
        chk("d038.pcif_pre", {7'd0, pcif}, 8'h00);
        cyc("pin08c", A_PIN, 1'b1, 1'b0, 8'h00, 1'b1, 8'h08, 1'b0);
        chk("d038.pcif_set", {7'd0, pcif}, 8'h01);
        idle("back0", 8'h00, 2);                 // event pending now
        cyc("clr_race", 6'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1);
        chk("d038.set_wins", {7'd0, pcif}, 8'h01);
        cyc("clr_only", 6'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1);
        chk("d038.cleared", {7'd0, pcif}, 8'h00);

        // masked toggle, gated write
        cyc("msk00", A_PCMSK, 1'b0, 1'b1, 8'h00, 1'b1, 8'h00, 1'b0);
        idle("mtog", 8'hFF, 4);
        chk("d039.pcif", {7'd0, pcif}, 8'h00);
        cyc("gated", A_PORT, 1'b0, 1'b1, 8'h99, 1'b0, 8'hFF, 1'b0);
        chk("d039.port", port_o, 8'h2C);

        // read and write the same address together
        cyc("rw_same", A_PORT, 1'b1, 1'b1, 8'h3C, 1'b1, 8'hFF, 1'b0);
        chk("d028.after", port_o, 8'h3C);
        cyc("unmapped", 6'h2A, 1'b0, 1'b1, 8'h55, 1'b1, 8'hFF, 1'b0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [5:0] ra;
            ra = ($urandom_range(0, 5) == 0) ? 6'($urandom) : 6'(3 + $urandom_range(0, 3));
            pud = 1'($urandom);
            cyc("rnd", ra, 1'($urandom), 1'($urandom), 8'($urandom),
                ($urandom_range(0, 3) != 0), 8'($urandom) & 8'($urandom),
                ($urandom_range(0, 7) == 0));
        end
        pud = 1'b0;

        // async reset mid-cycle with PORTx=FF and pcif=1
        cyc("ff", A_PORT, 1'b0, 1'b1, 8'hFF, 1'b1, 8'h00, 1'b0);
        cyc("msk_ff", A_PCMSK, 1'b0, 1'b1, 8'hFF, 1'b1, 8'h00, 1'b0);
        idle("flip", 8'h00, 2);
        idle("flip", 8'h01, 3);
        chk("d040.pcif_pre", {7'd0, pcif}, 8'h01);
        adr = A_PORT; iore = 1'b1;
        #2 ireset = 1'b1;
        #1;
        chk("d040.port_o", port_o, 8'h00);
        chk("d040.pue_o", pue_o, 8'h00);
        chk("d040.pcif", {7'd0, pcif}, 8'h00);
        chk("d040.dbusout", dbusout, 8'h00);
        model_reset();
        #1 ireset = 1'b0;
        #1;

        // reset between the read and write phases of a read-modify-write
        cyc("pre_ff", A_PORT, 1'b0, 1'b1, 8'hFF, 1'b1, 8'h01, 1'b0);
        cyc("rmw_rd", A_PORT, 1'b1, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0);
        #1 ireset = 1'b1;
        #1 ireset = 1'b0;
        model_reset();
        cyc("rmw_wr", A_PIN, 1'b0, 1'b1, 8'h01, 1'b1, 8'h01, 1'b0);
        chk("d032.port", port_o, 8'h01);
        chk("d031.pcif", {7'd0, pcif}, 8'h00);
        idle("tail", 8'h01, 3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
